// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB token constants, state encoding and CRC5 step
package usb_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   localparam logic [4:0] CRC5_POLY = 5'b00101;
   localparam logic [4:0] CRC5_INIT = 5'b11111;

   // addr[6:0] followed by endp[3:0], LSB first
   localparam int CRC_BITS = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CRC,
      ST_PID,
      ST_B1,
      ST_B2,
      ST_GAP
   } state_t;

   function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[4];
      return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
   endfunction

endpackage

// File: rtl/usb_crc5_serial.sv
// rtl/usb_crc5_serial.sv - bit-serial USB CRC5 register, one data bit per enabled cycle
module usb_crc5_serial
   import usb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       init,
   input  logic       en,
   input  logic       din,
   output logic [4:0] crc
);

   always_ff @(posedge clk) begin
      if (reset || init) begin
         crc <= CRC5_INIT;
      end else if (en) begin
         crc <= crc5_step(crc, din);
      end
   end

endmodule

// File: rtl/usb_token_tx.sv
// rtl/usb_token_tx.sv - builds a 3-byte USB token packet and sends it over a valid/ready byte port
module usb_token_tx
   import usb_pkg::*;
#(
   parameter int IDLE_GAP = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send_data,
   input  logic [3:0] pid,
   input  logic [6:0] addr,
   input  logic [3:0] endp,
   input  logic       tx_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       done
);

   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   state_t        state;
   state_t        next_state;
   logic [3:0]    pid_q;
   logic [6:0]    addr_q;
   logic [3:0]    endp_q;
   logic [3:0]    bit_cnt;
   logic [GW-1:0] gap_cnt;
   logic [4:0]    crc;
   logic [10:0]   crc_data;
   logic          accept;
   logic          last_bit;
   logic          gap_last;
   logic          tx_valid_d;
   logic [7:0]    tx_data_d;
   logic          done_d;

   assign accept   = (state == ST_IDLE) && send_data;
   assign crc_data = {endp_q, addr_q};
   assign last_bit = (bit_cnt == 4'(CRC_BITS - 1));
   assign gap_last = (gap_cnt == GW'(IDLE_GAP - 1));
   assign busy     = (state != ST_IDLE);

   usb_crc5_serial u_crc5 (
      .clk   (clk),
      .reset (reset),
      .init  (accept),
      .en    (state == ST_CRC),
      .din   (crc_data[bit_cnt]),
      .crc   (crc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (send_data) next_state = ST_CRC;
         ST_CRC:  if (last_bit) next_state = ST_PID;
         ST_PID:  if (tx_ready) next_state = ST_B1;
         ST_B1:   if (tx_ready) next_state = ST_B2;
         ST_B2:   if (tx_ready) next_state = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:  if (gap_last) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Output bytes are chosen from the upcoming state so they appear registered on entry
   always_comb begin
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      done_d     = (state == ST_B2) && tx_ready;
      case (next_state)
         ST_PID: begin
            tx_valid_d = 1'b1;
            tx_data_d  = {~pid_q, pid_q};
         end
         ST_B1: begin
            tx_valid_d = 1'b1;
            tx_data_d  = {endp_q[0], addr_q};
         end
         ST_B2: begin
            tx_valid_d = 1'b1;
            tx_data_d  = {~crc[0], ~crc[1], ~crc[2], ~crc[3], ~crc[4], endp_q[3:1]};
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pid_q   <= 4'h0;
         addr_q  <= 7'h00;
         endp_q  <= 4'h0;
         bit_cnt <= 4'd0;
         gap_cnt <= '0;
      end else begin
         if (accept) begin
            pid_q  <= pid;
            addr_q <= addr;
            endp_q <= endp;
         end
         bit_cnt <= (state == ST_CRC) ? bit_cnt + 4'd1 : 4'd0;
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
         done     <= 1'b0;
      end else begin
         tx_valid <= tx_valid_d;
         tx_data  <= tx_data_d;
         done     <= done_d;
      end
   end

endmodule

// File: doc/usb_token_tx.md
# usb_token_tx

Builds and transmits a 3-byte USB token packet (OUT, IN, SOF or SETUP) over a byte-wide valid/ready transmit interface. It is the transmit-side stage feeding the PHY byte port and is driven by the same `send_data` request used by the TX handshake logic. The block captures the PID, address and endpoint, computes CRC5 serially, then emits PID, ADDR/ENDP and ENDP/CRC5 bytes with per-byte flow control.

## Interface
- `IDLE_GAP`, default 2: number of cycles `tx_valid` stays low after the last byte before a new request is accepted (0 allowed).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `send_data` in 1: start request; sampled only in IDLE.
- `pid` in 4: token PID (OUT 4'b0001, IN 4'b1001, SOF 4'b0101, SETUP 4'b1101); captured with `send_data`.
- `addr` in 7: device address; captured with `send_data`.
- `endp` in 4: endpoint number; captured with `send_data`.
- `tx_ready` in 1: PHY accepts the byte when `tx_valid && tx_ready`.
- `tx_valid` out 1: `tx_data` holds a valid byte.
- `tx_data` out 8: transmit byte, LSB sent first on the wire.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after byte 2 is accepted.

## Operation
- States: IDLE, CRC, PID, B1, B2, GAP.
- IDLE: if `send_data`, register `pid`/`addr`/`endp`, load CRC to 5'b11111 and the bit counter to 0, then go to CRC. Otherwise stay in IDLE.
- CRC: one data bit per cycle for 11 cycles, in the order `addr[0]`..`addr[6]`, `endp[0]`..`endp[3]`.
  - Per bit b: `fb = b ^ crc[4]`; `crc = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b0)`.
  - After the 11th bit, go to PID.
- PID: `tx_data = {~pid, pid}`, `tx_valid = 1`. Hold until `tx_ready`, then go to B1.
- B1: `tx_data = {endp[0], addr[6:0]}`. Hold until `tx_ready`, then go to B2.
- B2: `tx_data[2:0] = endp[3:1]`; `tx_data[7:3] = bit-reverse of ~crc`, so `tx_data[3] = ~crc[4]` and `tx_data[7] = ~crc[0]`. Hold until `tx_ready`, then pulse `done` next cycle and go to GAP.
  - If `IDLE_GAP == 0`, go directly to IDLE.
- GAP: count `IDLE_GAP` cycles, then go to IDLE.
- `tx_data` and `tx_valid` are registered; `tx_data` is 8'h00 whenever `tx_valid` is low.
- `tx_data` must not change while `tx_valid && !tx_ready`.
- `send_data` outside IDLE is ignored; it is not queued.
- `tx_ready` while `tx_valid` is low is ignored.
- The captured fields are frozen from acceptance until return to IDLE; input changes meanwhile have no effect.

## Timing
- Reset values: state IDLE, `tx_valid = 0`, `tx_data = 8'h00`, `busy = 0`, `done = 0`, CRC = 5'b11111, counters 0.
- Let `send_data` be sampled at edge 0:
  - `busy = 1` from cycle 1.
  - CRC occupies cycles 1–11.
  - `tx_valid = 1` with the PID byte from cycle 12.
- With `tx_ready` held high, bytes are accepted at cycles 12, 13 and 14.
- `done = 1` in cycle 15, together with `busy = 1` and `tx_valid = 0`.
- With `IDLE_GAP = 2`, IDLE is reached in cycle 17; the earliest new acceptance is at edge 17.
- Back-pressure: each cycle with `tx_ready` low extends the packet by one cycle; `done` shifts by the same amount.
- Reset mid-operation, in any state: next cycle is IDLE with all outputs at reset values. No `done`, no partial byte.

## Structure
- Shared package `usb_pkg`:
  - PID constants `PID_OUT`, `PID_IN`, `PID_SOF`, `PID_SETUP`.
  - `CRC5_POLY` = 5'b00101 and `CRC5_INIT` = 5'b11111.
  - State encoding.
- Sub-module `usb_crc5_serial` with ports `clk`, `reset`, `init`, `en`, `din`, `crc[4:0]`. It is reused later by the receive-side token checker.
- Top level holds the FSM, the bit and gap counters, and the output registers.

## Test plan
- SETUP, addr 0, endp 0, `tx_ready` = 1 -> bytes 8'h2D, 8'h00, 8'h10 at cycles 12, 13, 14; `done` at 15.
- IN, addr 0, endp 0 -> bytes 8'h69, 8'h00, 8'h10. Random `pid`/`addr`/`endp` (≥500 packets) -> all bytes match a bit-serial reference CRC5 model, and the 16-bit ADDR/ENDP/CRC field checks to residual 5'b01100.
- `tx_ready` low for 3 cycles on each byte -> `tx_data` stable while stalled; `done` at cycle 24.
- `send_data` pulsed during CRC, B1 and GAP -> ignored; exactly one packet is sent.
- `reset` asserted during B1 -> next cycle `tx_valid = 0`, `busy = 0`, no `done`. A following request produces a complete, correct packet.
- `IDLE_GAP = 0` with `send_data` held high -> back-to-back packets, next `busy` cycle right after `done`. `IDLE_GAP = 2` -> exactly 2 idle cycles between `done` and IDLE.
